// File: rtl/truth_table_probe.sv
// -----------------------------------------------------------------------------
// truth_table_probe
//
// Purpose: characterizes one 3-input combinational gate. A run drives the
// eight input rows {in1,in2,in3} = 0..7 in order, holds each row for
// SETTLE_CYCLES clocks, samples the gate response at the end of each row and
// publishes the 8-bit truth table (row 0 in the MSB, so NAND(in1,in2) gives
// 8'hFC).
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start        in   request a run (only looked at while idle)
//   abort        in   cancel a run in progress (only acts while running)
//   in1,in2,in3  out  gate stimulus, {in1,in2,in3} = current row
//   dut_out      in   gate response
//   busy         out  run in progress
//   done         out  one-cycle pulse when table_out is updated
//   table_out    out  last complete truth table, bit (7-r) = response to row r
//   table_valid  out  table_out holds the result of the latest accepted run
//   unstable     out  dut_out moved inside a stability window in the last run
//
// Optional build macro: TT_PROBE_STABLE_CHECK_EN enables the stability
// monitor (last STABLE_WIN cycles of every row window). Without it unstable
// is held at 0 and STABLE_WIN only takes part in the parameter range check.
// -----------------------------------------------------------------------------
module truth_table_probe #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned STABLE_WIN    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  input  logic       dut_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic       table_valid,
  output logic       unstable
);

  if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 255) ||
      (STABLE_WIN < 1) || (STABLE_WIN > SETTLE_CYCLES)) begin : g_param_check
    $error("truth_table_probe: SETTLE_CYCLES/STABLE_WIN out of range");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_e     state_q,    state_d;
  logic [2:0] row_q,      row_d;
  logic [7:0] settle_q,   settle_d;
  logic [7:0] shadow_q,   shadow_d;
  logic [7:0] table_q,    table_d;
  logic       busy_q,     busy_d;
  logic       done_q,     done_d;
  logic       valid_q,    valid_d;
  logic       unstable_q, unstable_d;

  logic       row_end;
  logic [7:0] shadow_upd;
  logic       run_unstable;

  // Last cycle of the current row window: this edge samples dut_out.
  assign row_end = (settle_q == SETTLE_LAST);

  always_comb begin
    shadow_upd = shadow_q;
    shadow_upd[3'd7 - row_q] = dut_out;
  end

`ifdef TT_PROBE_STABLE_CHECK_EN
  localparam logic [7:0] WIN_FIRST = 8'(SETTLE_CYCLES - STABLE_WIN);

  logic ref_q,  ref_d;
  logic flag_q, flag_d;
  logic win_diff;

  // ref_q holds dut_out from the first window cycle; later window cycles
  // must match it.
  assign win_diff = (state_q == ST_RUN) && (settle_q > WIN_FIRST) &&
                    (dut_out != ref_q);

  always_comb begin
    ref_d  = ref_q;
    flag_d = flag_q;
    if ((state_q == ST_IDLE) && start) begin
      flag_d = 1'b0;
    end else if (state_q == ST_RUN) begin
      if (settle_q == WIN_FIRST) ref_d = dut_out;
      if (win_diff)              flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_q  <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      ref_q  <= ref_d;
      flag_q <= flag_d;
    end
  end

  // Include a difference seen on the final sample edge itself.
  assign run_unstable = flag_q | win_diff;
`else
  assign run_unstable = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    settle_d   = settle_q;
    shadow_d   = shadow_q;
    table_d    = table_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    valid_d    = valid_q;
    unstable_d = unstable_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_RUN;
          row_d      = 3'd0;
          settle_d   = 8'd0;
          shadow_d   = 8'h00;
          busy_d     = 1'b1;
          valid_d    = 1'b0;
          unstable_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (abort) begin
          // table_out keeps the previous result; valid stays cleared.
          state_d  = ST_IDLE;
          row_d    = 3'd0;
          settle_d = 8'd0;
          busy_d   = 1'b0;
        end else if (row_end) begin
          shadow_d = shadow_upd;
          settle_d = 8'd0;
          if (row_q == 3'd7) begin
            state_d    = ST_DONE;
            row_d      = 3'd0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            table_d    = shadow_upd;
            valid_d    = 1'b1;
            unstable_d = run_unstable;
          end else begin
            row_d = row_q + 3'd1;
          end
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      row_q      <= 3'd0;
      settle_q   <= 8'd0;
      shadow_q   <= 8'h00;
      table_q    <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      unstable_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      settle_q   <= settle_d;
      shadow_q   <= shadow_d;
      table_q    <= table_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
      unstable_q <= unstable_d;
    end
  end

  assign in1         = row_q[2];
  assign in2         = row_q[1];
  assign in3         = row_q[0];
  assign busy        = busy_q;
  assign done        = done_q;
  assign table_out   = table_q;
  assign table_valid = valid_q;
  assign unstable    = unstable_q;

endmodule

// File: tb/tb_truth_table_probe.sv
module tb_truth_table_probe;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       in1, in2, in3;
  logic       dut_out;
  logic       busy, done;
  logic [7:0] table_out;
  logic       table_valid, unstable;

  // Gate under characterization: 0 NAND(in1,in2), 1 in1, 2 const 1, 3 table tt
  int         gate_mode = 0;
  logic [7:0] tt = 8'h00;
  logic       glitch = 1'b0;
  logic       g;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  bit model_en = 1'b1;

  // Reference model state: phase 0 idle, 1 running, 2 done cycle
  int         m_phase = 0;
  int         m_el = 0;
  logic [7:0] m_gold = 8'h00;
  logic [7:0] m_table = 8'h00;
  logic       m_valid = 1'b0;

  truth_table_probe #(.SETTLE_CYCLES(S), .STABLE_WIN(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in1(in1), .in2(in2), .in3(in3), .dut_out(dut_out),
    .busy(busy), .done(done), .table_out(table_out),
    .table_valid(table_valid), .unstable(unstable)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic gate_fn(int mode, logic [7:0] t, logic a, logic b, logic c);
    case (mode)
      0:       return ~(a & b);
      1:       return a;
      2:       return 1'b1;
      default: return t[7 - int'({a, b, c})];
    endcase
  endfunction

  always_comb begin
    g = gate_fn(gate_mode, tt, in1, in2, in3);
    dut_out = g ^ glitch;
  end

  // Truth table the probe should report: row r's response lands in bit 7-r.
  function automatic logic [7:0] golden(int mode, logic [7:0] t);
    logic [7:0] r;
    logic [2:0] row;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      row = 3'(i);
      r[7 - i] = gate_fn(mode, t, row[2], row[1], row[0]);
    end
    return r;
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: a run is 8*S cycles after acceptance, row = elapsed/S.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase = 0; m_el = 0; m_table = 8'h00; m_valid = 1'b0;
    end else begin
      case (m_phase)
        0: if (start) begin
             m_phase = 1; m_el = 0; m_valid = 1'b0; m_gold = golden(gate_mode, tt);
           end
        1: if (abort) m_phase = 0;
           else begin
             m_el++;
             if (m_el == 8 * S) begin
               m_phase = 2; m_table = m_gold; m_valid = 1'b1;
             end
           end
        default: m_phase = 0;
      endcase
    end
    #1;
    if (model_en && rst_n) begin
      chk("busy", 8'(busy), 8'(m_phase == 1));
      chk("done", 8'(done), 8'(m_phase == 2));
      chk("rows", {5'b0, in1, in2, in3}, (m_phase == 1) ? 8'(m_el / S) : 8'h00);
      chk("table_out", table_out, m_table);
      chk("table_valid", 8'(table_valid), 8'(m_valid));
      chk("unstable", 8'(unstable), 8'h00);
    end
  end

  task automatic chk_reset_vals(string tag);
    chk({tag, "_rows"}, {5'b0, in1, in2, in3}, 8'h00);
    chk({tag, "_busy"}, 8'(busy), 8'h00);
    chk({tag, "_done"}, 8'(done), 8'h00);
    chk({tag, "_table"}, table_out, 8'h00);
    chk({tag, "_valid"}, 8'(table_valid), 8'h00);
    chk({tag, "_unstable"}, 8'(unstable), 8'h00);
  endtask

  // Pulse start for one edge; returns the cycle count right after acceptance.
  task automatic pulse_start(output int acc);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_done(input int acc, output int lat);
    lat = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        lat = cyc - acc;
        return;
      end
    end
    chk("done_timeout", 8'h00, 8'h01);
  endtask

  task automatic wait_until(input int target);
    for (int i = 0; i < 200; i++) begin
      if (cyc >= target) return;
      @(negedge clk);
    end
    chk("wait_timeout", 8'h00, 8'h01);
  endtask

  initial begin
    int acc, lat, n_done, n_fall;
    logic prev_busy;

    // Pin the reference model itself
    chk("model_nand", golden(0, 8'h00), 8'hFC);
    chk("model_in1", golden(1, 8'h00), 8'h0F);
    chk("model_one", golden(2, 8'h00), 8'hFF);

    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // NAND run: 32-cycle latency, 8'hFC
    gate_mode = 0;
    pulse_start(acc);
    wait_done(acc, lat);
    chk("nand_latency", 8'(lat), 8'd32);
    chk("nand_table", table_out, 8'hFC);
    chk("nand_valid", 8'(table_valid), 8'h01);

    // start held high: in1 run then a re-triggered const-1 run
    gate_mode = 1;
    @(negedge clk) start = 1'b1;
    acc = cyc + 1;
    wait_done(acc, lat);
    chk("in1_table", table_out, 8'h0F);
    gate_mode = 2;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    acc = cyc;
    chk("retrig_busy", 8'(busy), 8'h01);
    chk("retrig_valid_clr", 8'(table_valid), 8'h00);
    wait_done(acc, lat);
    chk("one_latency", 8'(lat), 8'd32);
    chk("one_table", table_out, 8'hFF);
    chk("one_valid", 8'(table_valid), 8'h01);

    // start pulses during a run are ignored
    gate_mode = 0;
    pulse_start(acc);
    n_done = 0; n_fall = 0; prev_busy = busy;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      start = (k == 5 || k == 20);
      if (done) n_done++;
      if (prev_busy && !busy) n_fall++;
      prev_busy = busy;
    end
    start = 1'b0;
    chk("ignored_start_dones", 8'(n_done), 8'd1);
    chk("ignored_start_busy_falls", 8'(n_fall), 8'd1);
    chk("ignored_start_table", table_out, 8'hFC);

    // abort mid-run
    gate_mode = 2;
    pulse_start(acc);
    wait_until(acc + 10);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    chk("abort_busy", 8'(busy), 8'h00);
    chk("abort_rows", {5'b0, in1, in2, in3}, 8'h00);
    chk("abort_table", table_out, 8'hFC);
    chk("abort_valid", 8'(table_valid), 8'h00);
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("abort_no_done", 8'(n_done), 8'd0);

    // async reset mid-run
    gate_mode = 1;
    pulse_start(acc);
    wait_until(acc + 13);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_reset");
    @(negedge clk) rst_n = 1'b1;
    gate_mode = 0;
    pulse_start(acc);
    wait_done(acc, lat);
    chk("post_reset_table", table_out, 8'hFC);
    chk("post_reset_valid", 8'(table_valid), 8'h01);

    // randomized start/abort/gate traffic
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      if (m_phase == 0 && ($urandom % 4) == 0) begin
        gate_mode = int'($urandom % 4);
        tt = 8'($urandom);
      end
      start = (($urandom % 6) == 0);
      abort = (($urandom % 60) == 0);
    end
    start = 1'b0;
    abort = 1'b0;
    repeat (40) @(negedge clk);

`ifdef TT_PROBE_STABLE_CHECK_EN
    // glitch in the final cycle of row 3, then a clean rerun
    model_en = 1'b0;
    gate_mode = 0;
    pulse_start(acc);
    wait_until(acc + 15);
    glitch = 1'b1;
    @(negedge clk) glitch = 1'b0;
    wait_done(acc, lat);
    chk("glitch_unstable", 8'(unstable), 8'h01);
    chk("glitch_table", table_out, 8'hEC);
    pulse_start(acc);
    wait_done(acc, lat);
    chk("clean_unstable", 8'(unstable), 8'h00);
    chk("clean_table", table_out, 8'hFC);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
